// File: rtl/obf_key_loader_if.sv
// Serial key-beat handshake between a key source and obf_key_loader.
// Signals: key_valid/key_bit (source -> loader), key_ready (loader -> source).
interface obf_key_loader_if;
    logic key_valid;
    logic key_bit;
    logic key_ready;

    modport master (
        output key_valid,
        output key_bit,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_bit,
        output key_ready
    );
endinterface

// File: rtl/obf_key_loader.sv
// Receives serial key frames (KEY_W bits LSB first + even parity), verifies them
// and drives the camouflaged-gate select bits; repeated parity failures lock out.
// Ports: clk, rst (sync, active-high), bus (slave: key_valid/key_bit/key_ready),
// key_out, key_applied, key_err, locked, fail_cnt.
module obf_key_loader #(
    parameter int NUM_GATES = 2,
    parameter int TIMEOUT   = 16,
    parameter int MAX_FAIL  = 3,
    localparam int KEY_W    = 2 * NUM_GATES,
    localparam int FCW      = $clog2(MAX_FAIL + 1),
    parameter logic [KEY_W-1:0] RST_KEY = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    obf_key_loader_if.slave      bus,
    output logic [KEY_W-1:0]     key_out,
    output logic                 key_applied,
    output logic                 key_err,
    output logic                 locked,
    output logic [FCW-1:0]       fail_cnt
);

    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_LOCK
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [KEY_W-1:0]   r_shadow;
    logic [KEY_W-1:0]   w_shadow_nx;
    logic [KEY_W-1:0]   r_key;
    logic [KEY_W-1:0]   w_key_nx;
    logic               r_parity;
    logic               w_parity_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [TMO_W-1:0]   r_tmo;
    logic [TMO_W-1:0]   w_tmo_nx;
    logic               r_ready;
    logic               w_ready_nx;
    logic               r_applied;
    logic               w_applied_nx;
    logic               r_err;
    logic               w_err_nx;
    logic               r_locked;
    logic               w_locked_nx;
    logic [FCW-1:0]     r_fail;
    logic [FCW-1:0]     w_fail_nx;
    logic [FCW-1:0]     w_fail_inc;
    logic               w_xfer;
    logic               w_par_ok;

    assign w_xfer   = bus.key_valid & r_ready;
    assign w_par_ok = ~(^{r_shadow, r_parity});

    // Saturating increment; lockout is reached before wrap could matter.
    assign w_fail_inc = (r_fail == FCW'(MAX_FAIL)) ? r_fail : r_fail + 1'b1;

    always_comb begin
        w_state_nx   = r_state;
        w_shadow_nx  = r_shadow;
        w_parity_nx  = r_parity;
        w_cnt_nx     = r_cnt;
        w_tmo_nx     = r_tmo;
        w_key_nx     = r_key;
        w_fail_nx    = r_fail;
        w_locked_nx  = r_locked;
        w_applied_nx = 1'b0;
        w_err_nx     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_tmo_nx = '0;
                if (w_xfer) begin
                    w_shadow_nx[0] = bus.key_bit;
                    w_cnt_nx       = CNT_W'(1);
                    w_state_nx     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_xfer) begin
                    w_tmo_nx = '0;
                    if (r_cnt == CNT_W'(KEY_W)) begin
                        w_parity_nx = bus.key_bit;
                        w_state_nx  = S_CHECK;
                    end else begin
                        for (int i = 0; i < KEY_W; i++) begin
                            if (r_cnt == CNT_W'(i)) begin
                                w_shadow_nx[i] = bus.key_bit;
                            end
                        end
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    // Stalled frame: drop it silently.
                    w_tmo_nx   = '0;
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_tmo_nx = r_tmo + 1'b1;
                end
            end
            S_CHECK: begin
                w_cnt_nx = '0;
                if (w_par_ok) begin
                    w_key_nx     = r_shadow;
                    w_applied_nx = 1'b1;
                    w_state_nx   = S_IDLE;
                end else begin
                    w_err_nx  = 1'b1;
                    w_fail_nx = w_fail_inc;
                    if (w_fail_inc == FCW'(MAX_FAIL)) begin
                        w_key_nx    = '1;
                        w_locked_nx = 1'b1;
                        w_state_nx  = S_LOCK;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_LOCK: begin
                // All ones forces every gate to CONST0.
                w_key_nx    = '1;
                w_locked_nx = 1'b1;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign w_ready_nx = (w_state_nx == S_IDLE) || (w_state_nx == S_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shadow  <= '0;
            r_parity  <= 1'b0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_key     <= RST_KEY;
            r_ready   <= 1'b0;
            r_applied <= 1'b0;
            r_err     <= 1'b0;
            r_locked  <= 1'b0;
            r_fail    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_shadow  <= w_shadow_nx;
            r_parity  <= w_parity_nx;
            r_cnt     <= w_cnt_nx;
            r_tmo     <= w_tmo_nx;
            r_key     <= w_key_nx;
            r_ready   <= w_ready_nx;
            r_applied <= w_applied_nx;
            r_err     <= w_err_nx;
            r_locked  <= w_locked_nx;
            r_fail    <= w_fail_nx;
        end
    end

    assign bus.key_ready = r_ready;
    assign key_out       = r_key;
    assign key_applied   = r_applied;
    assign key_err       = r_err;
    assign locked        = r_locked;
    assign fail_cnt      = r_fail;

endmodule

// File: doc/obf_key_loader.md
Name: obf_key_loader

Overview:
- Key-delivery end of the camouflaged-gate interface: accepts a serial key frame, checks parity, and drives the parallel select bits D_0..D_(2*NUM_GATES-1) into an obfuscated netlist such as c17 with its inserted ED_* select trees.
- Each gate g uses the pair {D_(2g+1), D_(2g)} with this encoding:
  - 00 = pass the original net
  - 10 = invert it
  - 01 = CONST1
  - 11 = CONST0
- Only verified frames reach the netlist.
- Repeated bad frames cause a lockout that drives every gate to CONST0.

Parameters:
NUM_GATES, 2, number of camouflaged gates; KEY_W = 2*NUM_GATES.
TIMEOUT, 16, maximum idle cycles between beats inside a frame before the frame is discarded.
MAX_FAIL, 3, parity failures allowed before lockout.
RST_KEY, {KEY_W{1'b0}}, key_out value at reset; all gates pass-through.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
key_valid  in  1  serial beat valid.
key_bit  in  1  serial data. Frame order: KEY_W key bits LSB first (D_0 first), then 1 even-parity bit.
key_ready  out  1  loader can accept a beat.
key_out  out  KEY_W  parallel select bits. key_out[i] drives D_i.
key_applied  out  1  one-cycle pulse when key_out is updated from a good frame.
key_err  out  1  one-cycle pulse on a parity failure.
locked  out  1  lockout active; sticky until rst.
fail_cnt  out  $clog2(MAX_FAIL+1)  parity failures since reset.

Behaviour:
- Reset values, applied at a clk edge with rst=1: state IDLE, key_out=RST_KEY, key_ready=0, key_applied=0, key_err=0, locked=0, fail_cnt=0, shadow=0, bit counter=0, timeout counter=0. rst overrides every other input.
- States: IDLE, SHIFT, CHECK, LOCKOUT.
- Transfer rule: a beat transfers on an edge where key_valid && key_ready.
- key_ready = 1 in IDLE and SHIFT, 0 in CHECK and LOCKOUT. It is a registered output.
- IDLE:
  - A transferred beat is key bit 0: shadow[0]<=key_bit, cnt<=1, state->SHIFT.
  - No beat: remain in IDLE.
- SHIFT:
  - Each transferred beat with cnt<KEY_W: shadow[cnt]<=key_bit, cnt++.
  - The beat at cnt==KEY_W is the parity bit: latch it, state->CHECK.
  - The timeout counter clears on every transferred beat and increments otherwise.
  - On reaching TIMEOUT: discard the frame, state->IDLE, no err, fail_cnt unchanged, key_out unchanged.
- CHECK, lasting exactly one cycle:
  - Pass when ^{shadow,parity}==0. On the next edge: key_out<=shadow, key_applied=1 for one cycle, state->IDLE.
  - Fail: key_err=1 for one cycle, fail_cnt++. If the new fail_cnt==MAX_FAIL: state->LOCKOUT, locked=1, key_out<=all ones. Otherwise state->IDLE with key_out unchanged.
- Latency: the parity beat transfers at edge E. key_out and key_applied, or key_err, change at edge E+1.
- LOCKOUT:
  - key_out held at all ones (every gate CONST0).
  - key_ready=0; key_valid is ignored.
  - Exit only via rst.
- key_out never changes mid-frame. A partial frame never reaches the outputs.
- A successful frame does not clear fail_cnt. fail_cnt saturates at MAX_FAIL.
- A beat with key_valid=1 during CHECK is not accepted (key_ready=0). The source must hold it.
- rst asserted mid-frame: shadow is discarded and key_out returns to RST_KEY on that edge.

Test Plan:
- Reset: assert rst for 2 cycles, release -> key_out=4'b0000, key_ready=1 the cycle after, locked=0, fail_cnt=0.
- Good frame, NUM_GATES=2: beats 0,1,1,0 then parity 0 on consecutive cycles -> one cycle after the parity beat, key_out=4'b0110 and key_applied=1 for exactly one cycle; key_ready=0 during CHECK.
- Bad parity: beats 1,0,0,0 then parity 0 -> key_err pulse, fail_cnt=1, key_out keeps its previous value 4'b0110.
- Timeout: send 2 beats, then idle 16 cycles -> state back to IDLE, no key_err, fail_cnt unchanged. A following full good frame 1,1,0,0,0 -> key_out=4'b0011.
- Lockout, MAX_FAIL=3: three bad-parity frames -> third key_err, locked=1, key_out=4'b1111, key_ready=0. A further valid frame is ignored. rst -> key_out=4'b0000, locked=0.
- Backpressure and reset mid-frame: hold key_valid=1 continuously -> only KEY_W+1 beats consumed per frame, none taken during CHECK. Assert rst after beat 2 -> no key_applied pulse, key_out=RST_KEY.
